// File: rtl/btn_input_conditioner.sv
// Button conditioner: 2-flop sync, per-lane debounce, lockout mask; level out by default.
// Define BTN_INPUT_CONDITIONER_EDGE_EN for a one-cycle press pulse per accepted press instead.
module btn_input_conditioner #(
  parameter int N_BTN           = 8,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int CNT_W           = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [N_BTN-1:0] btn_raw,
  input  logic [N_BTN-1:0] lockout,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_out,
  output logic             any_out
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [N_BTN-1:0] sync1_q;
  logic [N_BTN-1:0] sync2_q;
  logic [N_BTN-1:0] stable_q;
  logic [N_BTN-1:0] stable_d;
  logic [CNT_W-1:0] cnt_q [N_BTN];
  logic [CNT_W-1:0] cnt_d [N_BTN];

  // Count only while the synchronised input disagrees with the accepted level;
  // any agreement restarts the count, so short glitches never get through.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < N_BTN; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          stable_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      for (int i = 0; i < N_BTN; i++) cnt_q[i] <= '0;
    end else if (!ena) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      for (int i = 0; i < N_BTN; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q  <= btn_raw;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      for (int i = 0; i < N_BTN; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign btn_level = stable_q;

`ifdef BTN_INPUT_CONDITIONER_EDGE_EN
  logic [N_BTN-1:0] press_q;
  logic [N_BTN-1:0] press_d;

  assign press_d = stable_d & ~stable_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      press_q <= '0;
    end else if (!ena) begin
      press_q <= '0;
    end else begin
      press_q <= press_d;
    end
  end

  // Lockout is applied after the register so a masked pulse is simply lost.
  assign btn_out = press_q & ~lockout;
`else
  assign btn_out = stable_q & ~lockout;
`endif

  assign any_out = |btn_out;

endmodule
